// File: rtl/wt_cache_pkg.sv
// ----------------------------------------------------------------------------
// wt_cache_pkg : shared L1 <-> memory adapter types and conversion helpers
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package wt_cache_pkg;

  localparam int unsigned PLEN   = 32;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned TID_W  = 4;
  localparam int unsigned USER_W = 8;

  localparam logic [2:0] IC_FILL_SIZE = 3'd7;

  typedef enum logic [0:0] {
    L1_SRC_IC = 1'b0,
    L1_SRC_DC = 1'b1
  } l1_src_e;

  typedef enum logic [1:0] {
    L1_REQ_IFILL  = 2'd0,
    L1_REQ_LOAD   = 2'd1,
    L1_REQ_STORE  = 2'd2,
    L1_REQ_ATOMIC = 2'd3
  } l1_req_e;

  typedef enum logic [2:0] {
    L1_RTRN_IFILL_ACK  = 3'd0,
    L1_RTRN_LOAD_ACK   = 3'd1,
    L1_RTRN_STORE_ACK  = 3'd2,
    L1_RTRN_ATOMIC_ACK = 3'd3,
    L1_RTRN_INV_REQ    = 3'd4
  } l1_rtrn_e;

  typedef struct packed {
    logic              nc;
    logic [TID_W-1:0]  tid;
    logic [PLEN-1:0]   paddr;
  } icache_req_t;

  typedef struct packed {
    l1_req_e           rtype;
    logic              nc;
    logic [2:0]        size;
    logic [TID_W-1:0]  tid;
    logic [PLEN-1:0]   paddr;
    logic [XLEN-1:0]   data;
    logic [USER_W-1:0] user;
    logic [3:0]        amo_op;
  } dcache_req_t;

  typedef struct packed {
    l1_src_e           src;
    l1_req_e           rtype;
    logic              nc;
    logic [2:0]        size;
    logic [TID_W-1:0]  tid;
    logic [PLEN-1:0]   paddr;
    logic [XLEN-1:0]   data;
    logic [USER_W-1:0] user;
    logic [3:0]        amo_op;
  } l1_mem_req_t;

  typedef struct packed {
    l1_rtrn_e          rtype;
    logic [TID_W-1:0]  tid;
    logic [XLEN-1:0]   data;
  } l1_mem_rtrn_t;

  typedef struct packed {
    l1_rtrn_e          rtype;
    logic [TID_W-1:0]  tid;
    logic [XLEN-1:0]   data;
  } icache_rtrn_t;

  typedef struct packed {
    l1_rtrn_e          rtype;
    logic [TID_W-1:0]  tid;
    logic [XLEN-1:0]   data;
  } dcache_rtrn_t;

  function automatic l1_mem_req_t ic2mem(input icache_req_t req);
    l1_mem_req_t m;
    m        = '0;
    m.src    = L1_SRC_IC;
    m.rtype  = L1_REQ_IFILL;
    m.nc     = req.nc;
    m.size   = IC_FILL_SIZE;
    m.tid    = req.tid;
    m.paddr  = req.paddr;
    return m;
  endfunction

  function automatic l1_mem_req_t dc2mem(input dcache_req_t req);
    l1_mem_req_t m;
    m.src    = L1_SRC_DC;
    m.rtype  = req.rtype;
    m.nc     = req.nc;
    m.size   = req.size;
    m.tid    = req.tid;
    m.paddr  = req.paddr;
    m.data   = req.data;
    m.user   = req.user;
    m.amo_op = req.amo_op;
    return m;
  endfunction

  function automatic icache_rtrn_t rtrn2ic(input l1_mem_rtrn_t r);
    icache_rtrn_t o;
    o.rtype = r.rtype;
    o.tid   = r.tid;
    o.data  = r.data;
    return o;
  endfunction

  function automatic dcache_rtrn_t rtrn2dc(input l1_mem_rtrn_t r);
    dcache_rtrn_t o;
    o.rtype = r.rtype;
    o.tid   = r.tid;
    o.data  = r.data;
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wt_credit_cnt.sv
// ----------------------------------------------------------------------------
// wt_credit_cnt : outstanding-transaction credit counter, saturating at 0/Max
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wt_credit_cnt #(
  parameter int unsigned Max = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic zero_o,
  output logic underflow_o
);

  localparam int unsigned CNT_W = $clog2(Max + 1);

  logic [CNT_W-1:0] cnt;

  assign zero_o      = (cnt == '0);
  assign full_o      = (cnt == CNT_W'(Max));
  // A lone decrement at zero is reported and swallowed; the count never wraps.
  assign underflow_o = dec_i & ~inc_i & zero_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (inc_i & ~dec_i & ~full_o) begin
      cnt <= cnt + 1'b1;
    end else if (dec_i & ~inc_i & ~zero_o) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wt_l1_mem_arbiter.sv
// ----------------------------------------------------------------------------
// wt_l1_mem_arbiter : merges icache/dcache requests, routes memory returns
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wt_l1_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned MaxOutstandingIc = 2,
  parameter int unsigned MaxOutstandingDc = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         icache_data_req_i,
  output logic         icache_data_ack_o,
  input  icache_req_t  icache_data_i,
  input  logic         dcache_data_req_i,
  output logic         dcache_data_ack_o,
  input  dcache_req_t  dcache_data_i,
  output logic         mem_req_vld_o,
  input  logic         mem_req_rdy_i,
  output l1_mem_req_t  mem_req_o,
  input  logic         mem_rtrn_vld_i,
  input  l1_mem_rtrn_t mem_rtrn_i,
  output logic         icache_rtrn_vld_o,
  output icache_rtrn_t icache_rtrn_o,
  output logic         dcache_rtrn_vld_o,
  output dcache_rtrn_t dcache_rtrn_o,
  output logic         busy_o,
  output logic         err_o
);

  logic    free;
  logic    elig_ic, elig_dc;
  logic    gnt_ic, gnt_dc;
  l1_src_e rr_ptr;
  logic    ic_full, dc_full, ic_zero, dc_zero, ic_uflow, dc_uflow;
  logic    rtrn_to_ic, rtrn_to_dc, ic_dec, dc_dec;

  // Gated by reset so the acks read 0 while reset is held, even with requests pending.
  assign free    = rst_ni & (~mem_req_vld_o | mem_req_rdy_i);
  assign elig_ic = icache_data_req_i & ~ic_full;
  assign elig_dc = dcache_data_req_i & ~dc_full;
  assign gnt_ic  = free & elig_ic & (~elig_dc | (rr_ptr == L1_SRC_IC));
  assign gnt_dc  = free & elig_dc & (~elig_ic | (rr_ptr == L1_SRC_DC));

  assign icache_data_ack_o = gnt_ic;
  assign dcache_data_ack_o = gnt_dc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_req_vld_o <= 1'b0;
      mem_req_o     <= '0;
      rr_ptr        <= L1_SRC_IC;
    end else if (free) begin
      mem_req_vld_o <= gnt_ic | gnt_dc;
      if (gnt_ic) begin
        mem_req_o <= ic2mem(icache_data_i);
        rr_ptr    <= L1_SRC_DC;
      end else if (gnt_dc) begin
        mem_req_o <= dc2mem(dcache_data_i);
        rr_ptr    <= L1_SRC_IC;
      end
    end
  end

  always_comb begin
    rtrn_to_ic = 1'b0;
    rtrn_to_dc = 1'b0;
    ic_dec     = 1'b0;
    dc_dec     = 1'b0;
    if (mem_rtrn_vld_i) begin
      case (mem_rtrn_i.rtype)
        L1_RTRN_IFILL_ACK: begin
          rtrn_to_ic = 1'b1;
          ic_dec     = 1'b1;
        end
        L1_RTRN_LOAD_ACK, L1_RTRN_STORE_ACK, L1_RTRN_ATOMIC_ACK: begin
          rtrn_to_dc = 1'b1;
          dc_dec     = 1'b1;
        end
        // Invalidations go to both caches and carry no credit.
        L1_RTRN_INV_REQ: begin
          rtrn_to_ic = 1'b1;
          rtrn_to_dc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      icache_rtrn_vld_o <= 1'b0;
      dcache_rtrn_vld_o <= 1'b0;
      icache_rtrn_o     <= '0;
      dcache_rtrn_o     <= '0;
      err_o             <= 1'b0;
    end else begin
      icache_rtrn_vld_o <= rtrn_to_ic;
      dcache_rtrn_vld_o <= rtrn_to_dc;
      if (rtrn_to_ic) icache_rtrn_o <= rtrn2ic(mem_rtrn_i);
      if (rtrn_to_dc) dcache_rtrn_o <= rtrn2dc(mem_rtrn_i);
      err_o <= err_o | ic_uflow | dc_uflow;
    end
  end

  wt_credit_cnt #(
    .Max (MaxOutstandingIc)
  ) u_ic_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc_i       (gnt_ic),
    .dec_i       (ic_dec),
    .full_o      (ic_full),
    .zero_o      (ic_zero),
    .underflow_o (ic_uflow)
  );

  wt_credit_cnt #(
    .Max (MaxOutstandingDc)
  ) u_dc_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc_i       (gnt_dc),
    .dec_i       (dc_dec),
    .full_o      (dc_full),
    .zero_o      (dc_zero),
    .underflow_o (dc_uflow)
  );

  assign busy_o = ~ic_zero | ~dc_zero | mem_req_vld_o | icache_rtrn_vld_o | dcache_rtrn_vld_o;

endmodule

`default_nettype wire

// File: tb/tb_wt_l1_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wt_l1_mem_arbiter : directed + randomized bench with a transaction-level model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_wt_l1_mem_arbiter;
  import wt_cache_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         ic_req, ic_ack, dc_req, dc_ack;
  icache_req_t  ic_data;
  dcache_req_t  dc_data;
  logic         mem_vld, mem_rdy;
  l1_mem_req_t  mem_req;
  logic         rtrn_vld;
  l1_mem_rtrn_t rtrn;
  logic         ic_rv, dc_rv;
  icache_rtrn_t ic_rtrn;
  dcache_rtrn_t dc_rtrn;
  logic         busy, err;

  int nvec = 0;
  int nerr = 0;

  // Reference model: in-flight counts, arbitration preference, expected output stages.
  int          m_ic, m_dc;
  bit          m_pref_ic;
  bit          m_vld, m_src_dc;
  logic [31:0] m_paddr;
  logic [3:0]  m_tid;
  logic [63:0] m_data;
  bit          m_icrv, m_dcrv, m_err;
  logic [63:0] m_icd, m_dcd;
  int          n_ic_acks, n_dc_acks;

  wt_l1_mem_arbiter #(
    .MaxOutstandingIc (2),
    .MaxOutstandingDc (8)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .icache_data_req_i (ic_req),
    .icache_data_ack_o (ic_ack),
    .icache_data_i     (ic_data),
    .dcache_data_req_i (dc_req),
    .dcache_data_ack_o (dc_ack),
    .dcache_data_i     (dc_data),
    .mem_req_vld_o     (mem_vld),
    .mem_req_rdy_i     (mem_rdy),
    .mem_req_o         (mem_req),
    .mem_rtrn_vld_i    (rtrn_vld),
    .mem_rtrn_i        (rtrn),
    .icache_rtrn_vld_o (ic_rv),
    .icache_rtrn_o     (ic_rtrn),
    .dcache_rtrn_vld_o (dc_rv),
    .dcache_rtrn_o     (dc_rtrn),
    .busy_o            (busy),
    .err_o             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ic = 0; m_dc = 0; m_pref_ic = 1'b1;
    m_vld = 1'b0; m_src_dc = 1'b0; m_paddr = '0; m_tid = '0; m_data = '0;
    m_icrv = 1'b0; m_dcrv = 1'b0; m_err = 1'b0; m_icd = '0; m_dcd = '0;
  endtask

  task automatic rand_payloads();
    ic_data.nc     = 1'($urandom);
    ic_data.tid    = 4'($urandom);
    ic_data.paddr  = $urandom;
    dc_data.rtype  = l1_req_e'($urandom_range(1, 3));
    dc_data.nc     = 1'($urandom);
    dc_data.size   = 3'($urandom);
    dc_data.tid    = 4'($urandom);
    dc_data.paddr  = $urandom;
    dc_data.data   = {$urandom, $urandom};
    dc_data.user   = 8'($urandom);
    dc_data.amo_op = 4'($urandom);
  endtask

  task automatic set_rtrn(input bit vld, input logic [2:0] rt);
    rtrn_vld   = vld;
    rtrn.rtype = l1_rtrn_e'(rt);
    rtrn.tid   = 4'($urandom);
    rtrn.data  = {$urandom, $urandom};
  endtask

  // One clock: compare DUT against model at the negedge, then advance the model.
  task automatic cycle();
    bit free, e_ic, e_dc, a_ic, a_dc, ret_ic, ret_dc, to_ic, to_dc;
    logic [2:0] rt;
    @(negedge clk);
    free = !m_vld || mem_rdy;
    e_ic = ic_req && (m_ic < 2);
    e_dc = dc_req && (m_dc < 8);
    a_ic = free && e_ic && (!e_dc || m_pref_ic);
    a_dc = free && e_dc && (!e_ic || !m_pref_ic);
    chk("ic_ack", ic_ack, a_ic);
    chk("dc_ack", dc_ack, a_dc);
    chk("mem_vld", mem_vld, m_vld);
    if (m_vld) begin
      chk("mem_src", mem_req.src, m_src_dc);
      chk("mem_paddr", mem_req.paddr, m_paddr);
      chk("mem_tid", mem_req.tid, m_tid);
      if (m_src_dc) chk("mem_data", mem_req.data, m_data);
    end
    chk("ic_rtrn_vld", ic_rv, m_icrv);
    chk("dc_rtrn_vld", dc_rv, m_dcrv);
    if (m_icrv) chk("ic_rtrn_data", ic_rtrn.data, m_icd);
    if (m_dcrv) chk("dc_rtrn_data", dc_rtrn.data, m_dcd);
    chk("err", err, m_err);
    chk("busy", busy, (m_ic > 0) || (m_dc > 0) || m_vld || m_icrv || m_dcrv);
    n_ic_acks += int'(a_ic);
    n_dc_acks += int'(a_dc);

    if (free) begin
      m_vld = a_ic || a_dc;
      if (a_ic) begin
        m_src_dc = 1'b0; m_paddr = ic_data.paddr; m_tid = ic_data.tid;
      end else if (a_dc) begin
        m_src_dc = 1'b1; m_paddr = dc_data.paddr; m_tid = dc_data.tid; m_data = dc_data.data;
      end
    end
    if (a_ic) m_pref_ic = 1'b0;
    if (a_dc) m_pref_ic = 1'b1;

    rt     = rtrn.rtype;
    ret_ic = rtrn_vld && (rt == 3'd0);
    ret_dc = rtrn_vld && (rt == 3'd1 || rt == 3'd2 || rt == 3'd3);
    to_ic  = ret_ic || (rtrn_vld && rt == 3'd4);
    to_dc  = ret_dc || (rtrn_vld && rt == 3'd4);
    if (a_ic && !ret_ic) m_ic++;
    else if (!a_ic && ret_ic) begin
      if (m_ic == 0) m_err = 1'b1; else m_ic--;
    end
    if (a_dc && !ret_dc) m_dc++;
    else if (!a_dc && ret_dc) begin
      if (m_dc == 0) m_err = 1'b1; else m_dc--;
    end
    m_icrv = to_ic;
    m_dcrv = to_dc;
    if (to_ic) m_icd = rtrn.data;
    if (to_dc) m_dcd = rtrn.data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] first_paddr;
    int r;
    rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; mem_rdy = 1'b1;
    ic_data = '0; dc_data = '0; rtrn_vld = 1'b0; rtrn = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_vld", mem_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rtrn_vld", {ic_rv, dc_rv}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both sources saturate: IC gets 2 credits, DC gets 8, alternating while both eligible.
    ic_req = 1'b1; dc_req = 1'b1; mem_rdy = 1'b1;
    n_ic_acks = 0; n_dc_acks = 0;
    for (int i = 0; i < 12; i++) begin
      rand_payloads();
      cycle();
    end
    chk("t1_ic_acks", n_ic_acks, 2);
    chk("t1_dc_acks", n_dc_acks, 8);
    chk("t1_vld_drop", mem_vld, 0);

    // Full DC counter: a return frees a slot only for the following cycle.
    ic_req = 1'b0; dc_req = 1'b1; rand_payloads();
    set_rtrn(1'b1, 3'd1);
    #1 chk("t3_no_ack", dc_ack, 0);
    cycle();
    set_rtrn(1'b0, 3'd0);
    #1 chk("t3_ack", dc_ack, 1);
    cycle();
    dc_req = 1'b0;

    for (int i = 0; i < 10; i++) begin
      set_rtrn(1'b1, (i < 2) ? 3'd0 : 3'(1 + (i % 3)));
      cycle();
    end
    set_rtrn(1'b0, 3'd0);
    cycle();
    cycle();
    chk("drain_busy", busy, 0);

    // Invalidation fans out to both caches.
    set_rtrn(1'b1, 3'd4);
    cycle();
    chk("t4_ic_rv", ic_rv, 1);
    chk("t4_dc_rv", dc_rv, 1);
    set_rtrn(1'b0, 3'd0);
    cycle();

    // Store ack with nothing outstanding.
    set_rtrn(1'b1, 3'd2);
    cycle();
    set_rtrn(1'b0, 3'd0);
    chk("t5_err", err, 1);
    repeat (3) cycle();

    // Backpressure: payload held while stalled, next request taken on handoff.
    dc_req = 1'b1; mem_rdy = 1'b0; rand_payloads();
    first_paddr = dc_data.paddr;
    cycle();
    for (int i = 0; i < 5; i++) begin
      rand_payloads();
      cycle();
      chk("t2_stable", mem_req.paddr, first_paddr);
    end
    mem_rdy = 1'b1;
    #1 chk("t2_handoff_ack", dc_ack, 1);
    cycle();
    dc_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_rtrn(1'b1, 3'd1);
      cycle();
    end
    set_rtrn(1'b0, 3'd0);
    cycle();

    // Randomized traffic; returns are only issued against outstanding credits.
    for (int i = 0; i < 600; i++) begin
      ic_req  = 1'($urandom);
      dc_req  = 1'($urandom);
      mem_rdy = ($urandom % 4) != 0;
      rand_payloads();
      r = int'($urandom % 8);
      if (r < 2 && m_ic > 0)      set_rtrn(1'b1, 3'd0);
      else if (r < 5 && m_dc > 0) set_rtrn(1'b1, 3'($urandom_range(1, 3)));
      else if (r == 5)            set_rtrn(1'b1, 3'd4);
      else if (r == 6)            set_rtrn(1'b1, 3'($urandom_range(5, 7)));
      else                        set_rtrn(1'b0, 3'd0);
      cycle();
    end

    ic_req = 1'b0; dc_req = 1'b0; mem_rdy = 1'b1;
    for (int i = 0; i < 40 && (m_ic > 0 || m_dc > 0); i++) begin
      if (m_ic > 0) set_rtrn(1'b1, 3'd0);
      else          set_rtrn(1'b1, 3'd3);
      cycle();
    end
    set_rtrn(1'b0, 3'd0);
    cycle();
    chk("rand_drained", busy, 0);

    // Asynchronous reset with work in flight.
    dc_req = 1'b1; ic_req = 1'b1;
    repeat (3) begin
      rand_payloads();
      cycle();
    end
    chk("t6_pre_vld", mem_vld, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_vld", mem_vld, 0);
    chk("t6_acks", {ic_ack, dc_ack}, 0);
    chk("t6_rtrn_vld", {ic_rv, dc_rv}, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", err, 0);
    model_reset();
    ic_req = 1'b0; dc_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    chk("t6_busy_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
